// File: rtl/generador_pwm_pkg.sv
// Shared constants for the PWM output stage and its cs edge detector.
package generador_pwm_pkg;
  localparam int         PWM_WIDTH = 11;
  localparam logic [2:0] SYNC_IDLE = 3'b111;
endpackage

// File: rtl/generador_pwm_sync.sv
// Two-flop synchronizer plus edge register; pulses fall for one clk on a high->low input.
module sincronizador_flanco
  import generador_pwm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic fall
);
  // sh[0], sh[1] synchronize; sh[2] holds the previous synchronized level.
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (reset) sh <= SYNC_IDLE;
    else       sh <= {sh[1:0], d};
  end

  assign fall = sh[2] & ~sh[1];
endmodule

// File: rtl/generador_pwm.sv
// PWM output stage: duty word captured on cs fall, applied only at period boundaries.
module generador_pwm
  import generador_pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             en,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active
);
  localparam logic [WIDTH-1:0] CNT_MAX  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic             fall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pending;
  logic             pend_vld;
  logic [PW-1:0]    pre;
  logic             en_d;
  logic             run, tick, wrap, load;

  sincronizador_flanco u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (cs),
    .fall (fall)
  );

  // The first clk with en=1 is a lead-in: counter held at 0, period_start fires,
  // so a restarted period lines up exactly like one that follows a wrap.
  assign run  = en & en_d;
  assign tick = run & (pre == PRE_LAST);
  assign wrap = tick & (cnt == CNT_MAX);
  assign load = wrap | ~run;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      duty_active  <= '0;
      pending      <= '0;
      pend_vld     <= 1'b0;
      cnt          <= '0;
      pre          <= '0;
      en_d         <= 1'b0;
    end else begin
      en_d         <= en;
      period_start <= wrap | (en & ~en_d);
      pwm_out      <= run & (cnt < duty_active);

      if (!run) begin
        pre <= '0;
        cnt <= '0;
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
      end

      if (load && pend_vld) begin
        duty_active <= pending;
        pend_vld    <= 1'b0;
      end
      // A capture on the load clk wins over the clear: the new word waits a period.
      if (fall) begin
        pending  <= duty_in;
        pend_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_generador_pwm.sv
// Scoreboard bench: expected per-period duty/high-time/length queued by stimulus, checked at period_start.
module tb_generador_pwm;
  typedef struct packed {
    logic [10:0] duty;
    logic [15:0] hi;
    logic [15:0] len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, cs, en;
  logic [10:0] duty_in;
  logic        reset4, cs4, en4;
  logic [10:0] duty4;
  logic        pwm0, ps0, pwm4, ps4;
  logic [10:0] da0, da4;

  int   total = 0;
  int   bad   = 0;
  bit   done4 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  generador_pwm #(.WIDTH(11), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .cs(cs), .duty_in(duty_in), .en(en),
    .pwm_out(pwm0), .period_start(ps0), .duty_active(da0)
  );

  generador_pwm #(.WIDTH(11), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset4), .cs(cs4), .duty_in(duty4), .en(en4),
    .pwm_out(pwm4), .period_start(ps4), .duty_active(da4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ps(input bit which, input int budget, input string nm);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = which ? ps4 : ps0;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: no period_start within %0d clks", nm, budget);
    end
  endtask

  task automatic fall_cs(input logic [10:0] w);
    duty_in = w;
    cs      = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1;
  endtask

  function automatic exp_t mk(input logic [10:0] d, input int h, input int l);
    mk = '{duty: d, hi: 16'(h), len: 16'(l)};
  endfunction

  // Monitor: a window covers the pwm samples after one period_start up to and
  // including the next one (pwm_out lags the counter by a clk).
  initial begin
    int   hi[2];
    int   len[2];
    bit   open[2];
    bit   armed[2];
    exp_t cur[2];
    logic p, w, r;
    logic [10:0] d;
    for (int k = 0; k < 2; k++) begin open[k] = 0; armed[k] = 0; hi[k] = 0; len[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        r = (k == 0) ? reset : reset4;
        p = (k == 0) ? ps0 : ps4;
        w = (k == 0) ? pwm0 : pwm4;
        d = (k == 0) ? da0 : da4;
        if (r) begin
          open[k] = 0; armed[k] = 0;
        end else begin
          if (open[k]) begin hi[k] += int'(w); len[k]++; end
          if (p) begin
            if (open[k] && armed[k]) begin
              chk($sformatf("dut%0d high time duty=%0h", k, cur[k].duty), hi[k], 32'(cur[k].hi));
              chk($sformatf("dut%0d period length duty=%0h", k, cur[k].duty), len[k], 32'(cur[k].len));
            end
            open[k] = 1; hi[k] = 0; len[k] = 0; armed[k] = 0;
            if (k == 0 && q0.size() > 0) begin cur[k] = q0.pop_front(); armed[k] = 1; end
            if (k == 1 && q1.size() > 0) begin cur[k] = q1.pop_front(); armed[k] = 1; end
            if (armed[k]) chk($sformatf("dut%0d duty_active at period start", k), 32'(d), 32'(cur[k].duty));
          end
        end
      end
    end
  end

  // PRESCALE=4 instance: duty 2 -> 8 clks high out of 8188.
  initial begin
    reset4 = 1'b1; en4 = 1'b1; cs4 = 1'b1; duty4 = '0;
    repeat (3) @(negedge clk);
    q1.push_back(mk(11'h000, 0, 8188));
    reset4 = 1'b0;
    wait_ps(1'b1, 10, "dut4 first period");
    duty4 = 11'h002; cs4 = 1'b0;
    q1.push_back(mk(11'h002, 8, 8188));
    q1.push_back(mk(11'h002, 8, 8188));
    repeat (4) @(negedge clk);
    cs4 = 1'b1;
    repeat (3) wait_ps(1'b1, 8300, "dut4 period");
    done4 = 1;
  end

  initial begin
    bit fin;
    reset = 1'b1; en = 1'b1; cs = 1'b1; duty_in = '0;
    repeat (3) @(negedge clk);
    chk("reset pwm_out", 32'(pwm0), 0);
    chk("reset period_start", 32'(ps0), 0);
    chk("reset duty_active", 32'(da0), 0);

    // Mid-scale word, applied from the second period on.
    q0.push_back(mk(11'h000, 0, 2047));
    reset = 1'b0;
    wait_ps(1'b0, 10, "first period after reset");
    fall_cs(11'h400);
    q0.push_back(mk(11'h400, 1024, 2047));
    q0.push_back(mk(11'h400, 1024, 2047));
    wait_ps(1'b0, 2100, "p2");
    wait_ps(1'b0, 2100, "p3");

    // Extremes: 0 % then 100 %, no glitch across the wrap.
    fall_cs(11'h000);
    q0.push_back(mk(11'h000, 0, 2047));
    wait_ps(1'b0, 2100, "p4");
    fall_cs(11'h7FF);
    q0.push_back(mk(11'h7FF, 2047, 2047));
    wait_ps(1'b0, 2100, "p5");

    // Mid-period update must not disturb the running period.
    fall_cs(11'h600);
    q0.push_back(mk(11'h600, 1536, 2047));
    wait_ps(1'b0, 2100, "p6");
    repeat (1000) @(negedge clk);
    fall_cs(11'h100);
    q0.push_back(mk(11'h100, 256, 2047));
    wait_ps(1'b0, 2100, "p7");

    // Second capture lands on the wrap clk: old pending applies, new one waits.
    q0.push_back(mk(11'h200, 512, 2047));
    q0.push_back(mk(11'h300, 768, 2047));
    fall_cs(11'h200);
    repeat (2040) @(negedge clk);
    fall_cs(11'h300);
    wait_ps(1'b0, 2100, "p9");
    wait_ps(1'b0, 2100, "p10");

    // One-clk reset mid-period with a word pending.
    repeat (500) @(negedge clk);
    fall_cs(11'h0AA);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset pwm_out", 32'(pwm0), 0);
    chk("mid reset period_start", 32'(ps0), 0);
    chk("mid reset duty_active", 32'(da0), 0);
    chk("mid reset cnt", 32'(dut.cnt), 0);
    chk("mid reset pend_vld", 32'(dut.pend_vld), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("restart pulse after reset", 32'(ps0), 1);

    // en low for 5 clks.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("en=0 pwm_out", 32'(pwm0), 0);
      chk("en=0 period_start", 32'(ps0), 0);
    end
    q0.push_back(mk(11'h000, 0, 2047));
    en = 1'b1;
    wait_ps(1'b0, 4, "restart after en");
    wait_ps(1'b0, 2100, "period after restart");

    // While disabled the pending word passes straight to duty_active.
    en = 1'b0;
    fall_cs(11'h080);
    repeat (3) @(negedge clk);
    chk("en=0 transparent duty_active", 32'(da0), 32'h080);
    q0.push_back(mk(11'h080, 128, 2047));
    en = 1'b1;
    wait_ps(1'b0, 4, "restart 2");
    wait_ps(1'b0, 2100, "period after restart 2");

    fin = done4;
    for (int i = 0; i < 40000 && !fin; i++) begin
      @(negedge clk);
      fin = done4;
    end
    chk("dut4 sequence finished", 32'(fin), 1);
    chk("queue0 drained", 32'(q0.size()), 0);
    chk("queue1 drained", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
